// File: rtl/apb_controller.sv
// APB-side sequencer of the AHB-to-APB bridge. It turns qualified AHB transfers into APB setup/access pairs.
// A one-entry pending buffer holds a transfer that arrives during a write's AHB data phase.
module apb_controller (
  input  logic        hclk,
  input  logic        hreset,
  input  logic        valid,
  input  logic        hwrite,
  input  logic        hwrite_reg,
  input  logic [31:0] haddr,
  input  logic [31:0] haddr1,
  input  logic [31:0] hwdata,
  output logic [31:0] paddr,
  output logic [31:0] pwdata,
  output logic        pwrite,
  output logic [2:0]  pselx,
  output logic        penable,
  output logic        hready_out
);

  typedef enum logic [2:0] {
    IDLE, WWAIT, READ, WRITE, WRITEP, WENABLEP, RENABLE, WENABLE
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] paddr_q, paddr_d;
  logic [31:0] pwdata_q, pwdata_d;
  logic        pwrite_q, pwrite_d;
  logic [2:0]  pselx_q, pselx_d;
  logic        penable_q, penable_d;
  logic        hready_q, hready_d;
  logic [31:0] pend_addr_q, pend_addr_d;
  logic [31:0] pend_data_q, pend_data_d;
  logic        pend_write_q, pend_write_d;
  logic [2:0]  sel_next;

  // Each slave owns one 64 MB window starting at 0x8000_0000; anything else selects nothing.
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_sel
      assign sel_next[gi] = (paddr_d[31:26] == 6'(32 + gi));
    end
  endgenerate

  always_comb begin
    state_d      = state_q;
    paddr_d      = paddr_q;
    pwdata_d     = pwdata_q;
    pwrite_d     = pwrite_q;
    pend_addr_d  = pend_addr_q;
    pend_data_d  = pend_data_q;
    pend_write_d = pend_write_q;
    case (state_q)
      IDLE, RENABLE, WENABLE: begin
        if (valid && !hwrite) begin
          state_d  = READ;
          paddr_d  = haddr;
          pwrite_d = 1'b0;
        end else if (valid) begin
          state_d = WWAIT;
        end else begin
          state_d = IDLE;
        end
      end
      WWAIT: begin
        // Write data only exists now, one cycle after its address phase.
        state_d  = valid ? WRITEP : WRITE;
        paddr_d  = haddr1;
        pwdata_d = hwdata;
        pwrite_d = 1'b1;
      end
      READ:  state_d = RENABLE;
      WRITE: state_d = WENABLE;
      WRITEP: begin
        state_d      = WENABLEP;
        pend_addr_d  = haddr1;
        pend_data_d  = hwdata;
        pend_write_d = hwrite_reg;
      end
      WENABLEP: begin
        paddr_d  = pend_addr_q;
        pwrite_d = pend_write_q;
        if (pend_write_q) begin
          state_d  = WRITE;
          pwdata_d = pend_data_q;
        end else begin
          state_d = READ;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    pselx_d   = 3'b000;
    penable_d = 1'b0;
    hready_d  = 1'b1;
    case (state_d)
      READ, WRITE, WRITEP: begin
        pselx_d  = sel_next;
        hready_d = 1'b0;
      end
      WENABLEP: begin
        pselx_d   = pselx_q;
        penable_d = 1'b1;
        hready_d  = 1'b0;
      end
      RENABLE, WENABLE: begin
        pselx_d   = pselx_q;
        penable_d = 1'b1;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge hclk) begin
    if (hreset) begin
      state_q      <= IDLE;
      paddr_q      <= 32'h0;
      pwdata_q     <= 32'h0;
      pwrite_q     <= 1'b0;
      pselx_q      <= 3'b000;
      penable_q    <= 1'b0;
      hready_q     <= 1'b1;
      pend_addr_q  <= 32'h0;
      pend_data_q  <= 32'h0;
      pend_write_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      paddr_q      <= paddr_d;
      pwdata_q     <= pwdata_d;
      pwrite_q     <= pwrite_d;
      pselx_q      <= pselx_d;
      penable_q    <= penable_d;
      hready_q     <= hready_d;
      pend_addr_q  <= pend_addr_d;
      pend_data_q  <= pend_data_d;
      pend_write_q <= pend_write_d;
    end
  end

  assign paddr      = paddr_q;
  assign pwdata     = pwdata_q;
  assign pwrite     = pwrite_q;
  assign pselx      = pselx_q;
  assign penable    = penable_q;
  assign hready_out = hready_q;

endmodule

// File: tb/tb_apb_controller.sv
// Bench for apb_controller: cycle-exact vector table, a reset-in-flight sequence,
// then random AHB traffic checked against an in-order APB transfer queue.
module tb_apb_controller;

  logic        hclk = 1'b0;
  logic        hreset, valid, hwrite, hwrite_reg;
  logic [31:0] haddr, haddr1, hwdata;
  logic [31:0] paddr, pwdata;
  logic        pwrite, penable, hready_out;
  logic [2:0]  pselx;

  int errors = 0;
  int checks = 0;

  apb_controller dut (
    .hclk(hclk), .hreset(hreset), .valid(valid), .hwrite(hwrite), .hwrite_reg(hwrite_reg),
    .haddr(haddr), .haddr1(haddr1), .hwdata(hwdata),
    .paddr(paddr), .pwdata(pwdata), .pwrite(pwrite), .pselx(pselx),
    .penable(penable), .hready_out(hready_out)
  );

  always #5 hclk = ~hclk;

  typedef struct packed {
    logic [31:0] rst, v, w, a, d;
    logic [31:0] e_paddr, e_pwdata, e_pwrite, e_psel, e_pen, e_rdy;
  } vec_t;

  vec_t vecs[$];

  // reference-model state for the random phase
  logic [31:0] q_addr[$];
  logic [31:0] q_data[$];
  logic        q_wr[$];
  logic [31:0] last_wdata;
  logic [31:0] prev_paddr;
  logic        prev_pwrite, prev_pen;
  logic [2:0]  prev_psel;
  int          low_run;

  function automatic vec_t mk(input logic [31:0] rst, v, w, a, d, ea, ed, ew, es, en, er);
    vec_t t;
    t.rst = rst; t.v = v; t.w = w; t.a = a; t.d = d;
    t.e_paddr = ea; t.e_pwdata = ed; t.e_pwrite = ew; t.e_psel = es; t.e_pen = en; t.e_rdy = er;
    return t;
  endfunction

  function automatic logic [2:0] model_sel(input logic [31:0] a);
    if (a < 32'h8000_0000 || a >= 32'h8C00_0000) return 3'b000;
    return 3'(32'd1 << ((a - 32'h8000_0000) / 32'h0400_0000));
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic [31:0] ea, ed, ew, es, en, er);
    check({tag, " paddr"}, paddr, ea);
    check({tag, " pwdata"}, pwdata, ed);
    check({tag, " pwrite"}, 32'(pwrite), ew);
    check({tag, " pselx"}, 32'(pselx), es);
    check({tag, " penable"}, 32'(penable), en);
    check({tag, " hready_out"}, 32'(hready_out), er);
  endtask

  task automatic drive(input logic r, input logic v, input logic w, input logic [31:0] a, input logic [31:0] d);
    hreset = r; valid = v; hwrite = w; haddr = a; hwdata = d;
  endtask

  // One clock; the upstream one-cycle delays of haddr/hwrite are modelled here.
  task automatic step();
    logic [31:0] a;
    logic        w;
    a = haddr;
    w = hwrite;
    @(posedge hclk);
    #1;
    haddr1     = a;
    hwrite_reg = w;
  endtask

  task automatic monitor();
    logic [31:0] ea, ed;
    logic        ew;
    if (hready_out) low_run = 0;
    else begin
      low_run++;
      check("rnd hready low run <= 3", 32'(low_run > 3), 32'd0);
    end
    if (!penable && pselx != 3'b000)
      check("rnd setup pselx", 32'(pselx), 32'(model_sel(paddr)));
    if (penable) begin
      check("rnd access follows setup",
            32'({prev_pen, prev_psel != 3'b000, prev_paddr == paddr, prev_pwrite == pwrite, prev_psel == pselx}),
            32'(5'b01111));
      if (q_addr.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rnd phantom access: paddr %h seen with no transfer outstanding", paddr);
      end else begin
        ea = q_addr.pop_front();
        ed = q_data.pop_front();
        ew = q_wr.pop_front();
        $display("apb %s paddr=%h pwdata=%h pselx=%b", pwrite ? "write" : "read ", paddr, pwdata, pselx);
        check("rnd paddr", paddr, ea);
        check("rnd pwrite", 32'(pwrite), 32'(ew));
        check("rnd pselx", 32'(pselx), 32'(model_sel(ea)));
        if (ew) begin
          check("rnd write pwdata", pwdata, ed);
          last_wdata = ed;
        end else begin
          check("rnd read keeps pwdata", pwdata, last_wdata);
        end
      end
    end
    prev_pen    = penable;
    prev_psel   = pselx;
    prev_paddr  = paddr;
    prev_pwrite = pwrite;
  endtask

  initial begin
    logic        acc, acc_w;
    logic [31:0] wdat;
    vec_t        t;

    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    haddr1 = 32'h0;
    hwrite_reg = 1'b0;

    //            rst v w  haddr         hwdata        paddr         pwdata        wr psel pen rdy
    vecs.push_back(mk(1, 0, 0, 'h0,          'h0,          'h0,          'h0,          0, 'b000, 0, 1));
    vecs.push_back(mk(1, 0, 0, 'h0,          'h0,          'h0,          'h0,          0, 'b000, 0, 1));
    vecs.push_back(mk(0, 1, 0, 'h8400_0010,  'h0,          'h8400_0010,  'h0,          0, 'b010, 0, 0));
    vecs.push_back(mk(0, 0, 0, 'h0,          'h0,          'h8400_0010,  'h0,          0, 'b010, 1, 1));
    vecs.push_back(mk(0, 0, 0, 'h0,          'h0,          'h8400_0010,  'h0,          0, 'b000, 0, 1));
    vecs.push_back(mk(0, 1, 1, 'h8000_0004,  'h0,          'h8400_0010,  'h0,          0, 'b000, 0, 1));
    vecs.push_back(mk(0, 0, 0, 'h0,          'hDEAD_BEEF,  'h8000_0004,  'hDEAD_BEEF,  1, 'b001, 0, 0));
    vecs.push_back(mk(0, 0, 0, 'h0,          'h0,          'h8000_0004,  'hDEAD_BEEF,  1, 'b001, 1, 1));
    vecs.push_back(mk(0, 1, 1, 'h8800_0000,  'h0,          'h8000_0004,  'hDEAD_BEEF,  1, 'b000, 0, 1));
    vecs.push_back(mk(0, 1, 1, 'h8000_0008,  'h1111_1111,  'h8800_0000,  'h1111_1111,  1, 'b100, 0, 0));
    vecs.push_back(mk(0, 0, 0, 'h0,          'h2222_2222,  'h8800_0000,  'h1111_1111,  1, 'b100, 1, 0));
    vecs.push_back(mk(0, 0, 0, 'h0,          'h0,          'h8000_0008,  'h2222_2222,  1, 'b001, 0, 0));
    vecs.push_back(mk(0, 0, 0, 'h0,          'h0,          'h8000_0008,  'h2222_2222,  1, 'b001, 1, 1));
    vecs.push_back(mk(0, 0, 0, 'h0,          'h0,          'h8000_0008,  'h2222_2222,  1, 'b000, 0, 1));
    vecs.push_back(mk(0, 1, 1, 'h8000_0000,  'h0,          'h8000_0008,  'h2222_2222,  1, 'b000, 0, 1));
    vecs.push_back(mk(0, 1, 0, 'h8400_0000,  'h3333_3333,  'h8000_0000,  'h3333_3333,  1, 'b001, 0, 0));
    vecs.push_back(mk(0, 0, 0, 'h0,          'h4444_4444,  'h8000_0000,  'h3333_3333,  1, 'b001, 1, 0));
    vecs.push_back(mk(0, 0, 0, 'h0,          'h0,          'h8400_0000,  'h3333_3333,  0, 'b010, 0, 0));
    vecs.push_back(mk(0, 0, 0, 'h0,          'h0,          'h8400_0000,  'h3333_3333,  0, 'b010, 1, 1));
    vecs.push_back(mk(0, 1, 0, 'h8000_0000,  'h0,          'h8000_0000,  'h3333_3333,  0, 'b001, 0, 0));
    vecs.push_back(mk(0, 0, 0, 'h0,          'h0,          'h8000_0000,  'h3333_3333,  0, 'b001, 1, 1));
    vecs.push_back(mk(0, 1, 0, 'h8000_0004,  'h0,          'h8000_0004,  'h3333_3333,  0, 'b001, 0, 0));
    vecs.push_back(mk(0, 1, 1, 'h8800_0000,  'h0,          'h8000_0004,  'h3333_3333,  0, 'b001, 1, 1));
    vecs.push_back(mk(0, 1, 0, 'h87FF_FFFC,  'h0,          'h87FF_FFFC,  'h3333_3333,  0, 'b010, 0, 0));
    vecs.push_back(mk(0, 0, 0, 'h0,          'h0,          'h87FF_FFFC,  'h3333_3333,  0, 'b010, 1, 1));
    vecs.push_back(mk(0, 1, 0, 'h8C00_0000,  'h0,          'h8C00_0000,  'h3333_3333,  0, 'b000, 0, 0));
    vecs.push_back(mk(0, 0, 0, 'h0,          'h0,          'h8C00_0000,  'h3333_3333,  0, 'b000, 1, 1));
    vecs.push_back(mk(0, 0, 0, 'h0,          'h0,          'h8C00_0000,  'h3333_3333,  0, 'b000, 0, 1));
    vecs.push_back(mk(0, 1, 0, 'h8BFF_FFFC,  'h0,          'h8BFF_FFFC,  'h3333_3333,  0, 'b100, 0, 0));
    vecs.push_back(mk(0, 0, 0, 'h0,          'h0,          'h8BFF_FFFC,  'h3333_3333,  0, 'b100, 1, 1));
    vecs.push_back(mk(0, 0, 0, 'h0,          'h0,          'h8BFF_FFFC,  'h3333_3333,  0, 'b000, 0, 1));

    foreach (vecs[i]) begin
      t = vecs[i];
      drive(t.rst[0], t.v[0], t.w[0], t.a, t.d);
      step();
      $display("vec %0d: valid=%b hwrite=%b haddr=%h -> paddr=%h pselx=%b penable=%b hready_out=%b",
               i, t.v[0], t.w[0], t.a, paddr, pselx, penable, hready_out);
      check_outs($sformatf("vec%0d", i), t.e_paddr, t.e_pwdata, t.e_pwrite, t.e_psel, t.e_pen, t.e_rdy);
    end

    // reset taken in WENABLE abandons the access
    drive(1'b0, 1'b1, 1'b1, 32'h8800_0010, 32'h0);
    step();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h5555_5555);
    step();
    check_outs("rstseq write", 32'h8800_0010, 32'h5555_5555, 1, 'b100, 0, 0);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    step();
    check_outs("rstseq wenable", 32'h8800_0010, 32'h5555_5555, 1, 'b100, 1, 1);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    step();
    check_outs("rstseq reset1", 32'h0, 32'h0, 0, 'b000, 0, 1);
    step();
    check_outs("rstseq reset2", 32'h0, 32'h0, 0, 'b000, 0, 1);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    step();
    check_outs("rstseq idle", 32'h0, 32'h0, 0, 'b000, 0, 1);
    $display("reset-in-flight sequence done");

    // random traffic against the transfer-queue model
    last_wdata  = 32'h0;
    low_run     = 0;
    prev_pen    = penable;
    prev_psel   = pselx;
    prev_paddr  = paddr;
    prev_pwrite = pwrite;
    for (int c = 0; c < 3000; c++) begin
      acc   = 1'b0;
      acc_w = 1'b0;
      wdat  = $urandom;
      if (hready_out && $urandom_range(0, 3) != 0) begin
        acc    = 1'b1;
        acc_w  = 1'($urandom_range(0, 1));
        valid  = 1'b1;
        hwrite = acc_w;
        haddr  = 32'h8000_0000 + 32'($urandom_range(0, 2)) * 32'h0400_0000
               + (32'($urandom_range(0, 24'hFF_FFFF)) << 2);
        q_addr.push_back(haddr);
        q_wr.push_back(acc_w);
        q_data.push_back(wdat);
      end else begin
        valid  = 1'b0;
        hwrite = 1'($urandom_range(0, 1));
        haddr  = $urandom;
      end
      step();
      if (acc) hwdata = acc_w ? wdat : $urandom;
      monitor();
    end

    valid = 1'b0;
    for (int c = 0; c < 20; c++) begin
      haddr = $urandom;
      step();
      monitor();
    end
    check("rnd all transfers performed", 32'(q_addr.size()), 32'd0);
    check("rnd idle after drain", 32'({hready_out, penable, pselx}), 32'(5'b10000));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
